// File: rtl/ether_pkg.sv
// Shared definitions for the RMII Ethernet datapath (transmit and receive sides).
package ether_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    FCS,
    IFG
  } tx_state_e;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;
  localparam logic [31:0] CRC_POLY       = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT       = 32'hFFFFFFFF;

  // Reflected CRC-32 advanced by one dibit, d[0] entering first.
  function automatic logic [31:0] crc_step2(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

endpackage

// File: rtl/ether_crc32_dibit.sv
// CRC-32 accumulator consuming one dibit per enabled cycle; shared with the receiver.
module crc32_dibit
  import ether_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [1:0]  d,
  output logic [31:0] crc
);

  logic [31:0] crc_d, crc_q;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc_step2(crc_q, d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= CRC_INIT;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/ether_tx.sv
// RMII transmitter: preamble/SFD, payload dibits, CRC-32 FCS and inter-frame gap.
module ether_tx
  import ether_pkg::*;
#(
  parameter int unsigned PREAMBLE_DIBITS = 31,
  parameter int unsigned IFG_DIBITS      = 48,
  parameter bit          ENABLE_FCS      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  input  logic       axiil,
  output logic       axiir,
  output logic       txen,
  output logic [1:0] txd,
  output logic       busy,
  output logic       err
);

  tx_state_e   state_d, state_q;
  logic [5:0]  cnt_d, cnt_q;
  logic [1:0]  align_d, align_q;
  logic        txen_d, txen_q;
  logic [1:0]  txd_d, txd_q;
  logic        busy_d, busy_q;
  logic        err_d, err_q;
  logic        accept;
  logic        crc_init;
  logic [31:0] crc;

  assign axiir  = (state_q == SFD) || (state_q == DATA);
  assign accept = axiir && axiiv;

  crc32_dibit u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (accept),
    .d    (axiid),
    .crc  (crc)
  );

  // Output registers are loaded with the dibit for the coming cycle, so the
  // SFD dibit is queued on the last preamble cycle and lands while in SFD.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    align_d  = align_q;
    txen_d   = 1'b0;
    txd_d    = 2'b00;
    err_d    = 1'b0;
    crc_init = 1'b0;
    case (state_q)
      IDLE: begin
        if (axiiv) begin
          state_d  = PREAMBLE;
          cnt_d    = 6'd0;
          align_d  = 2'd0;
          crc_init = 1'b1;
          txen_d   = 1'b1;
          txd_d    = PREAMBLE_DIBIT;
        end
      end
      PREAMBLE: begin
        txen_d = 1'b1;
        txd_d  = PREAMBLE_DIBIT;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'(PREAMBLE_DIBITS - 1)) begin
          txd_d   = SFD_DIBIT;
          cnt_d   = 6'd0;
          state_d = SFD;
        end
      end
      SFD, DATA: begin
        if (axiiv) begin
          txen_d  = 1'b1;
          txd_d   = axiid;
          align_d = align_q + 2'd1;
          state_d = DATA;
          if (axiil) begin
            err_d   = (align_q != 2'd3);
            cnt_d   = 6'd0;
            state_d = ENABLE_FCS ? FCS : IFG;
          end
        end else begin
          err_d   = 1'b1;
          cnt_d   = 6'd0;
          state_d = IFG;
        end
      end
      FCS: begin
        txen_d = 1'b1;
        txd_d  = ~crc[{cnt_q[3:0], 1'b0} +: 2];
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd15) begin
          cnt_d   = 6'd0;
          state_d = IFG;
        end
      end
      IFG: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(IFG_DIBITS - 1)) begin
          cnt_d   = 6'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      align_q <= 2'd0;
      txen_q  <= 1'b0;
      txd_q   <= 2'b00;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      align_q <= align_d;
      txen_q  <= txen_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign txen = txen_q;
  assign txd  = txd_q;
  assign busy = busy_q;
  assign err  = err_q;

endmodule
